// File: rtl/au_cascade_sched.sv
// rtl/au_cascade_sched.sv - time-multiplexes one filter-stage engine across the LPF cascade stages
// Each accepted sample walks the non-bypassed stages in ascending order, then leaves on a valid/ready port.
module au_cascade_sched #(
    parameter int NumStages     = 4,
    parameter int DataWidth     = 16,
    parameter int CntWidth      = 16,
    parameter int StageIdxWidth = (NumStages > 1) ? $clog2(NumStages) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cfg_en_i,
    input  logic [NumStages-1:0]     cfg_bypass_i,
    input  logic                     cfg_clr_i,
    input  logic                     in_valid_i,
    input  logic [DataWidth-1:0]     in_data_i,
    output logic                     eng_req_o,
    output logic [StageIdxWidth-1:0] eng_stage_o,
    output logic [DataWidth-1:0]     eng_data_o,
    input  logic                     eng_gnt_i,
    input  logic                     eng_rvalid_i,
    input  logic [DataWidth-1:0]     eng_rdata_i,
    output logic                     out_valid_o,
    output logic [DataWidth-1:0]     out_data_o,
    input  logic                     out_ready_i,
    output logic                     busy_o,
    output logic [CntWidth-1:0]      sample_cnt_o,
    output logic [CntWidth-1:0]      overrun_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [DataWidth-1:0]     acc_q, acc_d;
    logic [StageIdxWidth-1:0] idx_q, idx_d;
    logic [NumStages-1:0]     mask_q, mask_d;
    logic [CntWidth-1:0]      sample_cnt_q, sample_cnt_d;
    logic [CntWidth-1:0]      overrun_cnt_q, overrun_cnt_d;

    logic                     strobe;
    logic                     accept;
    logic                     overrun;
    logic                     out_hs;
    logic                     first_found;
    logic [StageIdxWidth-1:0] first_idx;
    logic                     next_found;
    logic [StageIdxWidth-1:0] next_idx;

    assign strobe  = in_valid_i & cfg_en_i;
    assign accept  = strobe & (state_q == IDLE);
    assign overrun = strobe & (state_q != IDLE);
    assign out_hs  = (state_q == OUT) & out_ready_i;

    // First stage comes from the live bypass config, later ones from the mask latched at accept.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int s = NumStages - 1; s >= 0; s--) begin
            if (!cfg_bypass_i[s]) begin
                first_found = 1'b1;
                first_idx   = StageIdxWidth'(s);
            end
        end
    end

    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int s = NumStages - 1; s >= 0; s--) begin
            if (!mask_q[s] && (s > int'(idx_q))) begin
                next_found = 1'b1;
                next_idx   = StageIdxWidth'(s);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            idx_q         <= '0;
            mask_q        <= '0;
            sample_cnt_q  <= '0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            mask_q        <= mask_d;
            sample_cnt_q  <= sample_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_data_i;
                    mask_d  = cfg_bypass_i;
                    idx_d   = first_idx;
                    state_d = first_found ? ISSUE : OUT;
                end
            end
            ISSUE: begin
                if (eng_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (eng_rvalid_i) begin
                    acc_d = eng_rdata_i;
                    if (next_found) begin
                        idx_d   = next_idx;
                        state_d = ISSUE;
                    end else begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a same-cycle increment; the overrun count sticks at all-ones.
    always_comb begin
        sample_cnt_d  = sample_cnt_q + {{(CntWidth-1){1'b0}}, out_hs};
        overrun_cnt_d = overrun_cnt_q;
        if (overrun && !(&overrun_cnt_q)) begin
            overrun_cnt_d = overrun_cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
        end
        if (cfg_clr_i) begin
            sample_cnt_d  = '0;
            overrun_cnt_d = '0;
        end
    end

    always_comb begin
        eng_req_o     = 1'b0;
        eng_stage_o   = '0;
        eng_data_o    = '0;
        out_valid_o   = 1'b0;
        out_data_o    = '0;
        busy_o        = (state_q != IDLE);
        sample_cnt_o  = sample_cnt_q;
        overrun_cnt_o = overrun_cnt_q;
        unique case (state_q)
            ISSUE: begin
                eng_req_o   = 1'b1;
                eng_stage_o = idx_q;
                eng_data_o  = acc_q;
            end
            OUT: begin
                out_valid_o = 1'b1;
                out_data_o  = acc_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/au_cascade_sched.md
Name: au_cascade_sched

Overview:
- Per-sample scheduler that time-multiplexes one shared filter-stage engine across the NumStages stages of the user-domain LPF cascade.
- Accepts one sample strobe from the audio interface and issues it to the engine once per non-bypassed stage, in ascending stage order.
- Each stage's result feeds the next stage; the final result goes out on a valid/ready port.
- Configuration and status connect as ports to the LPF cascade register block.

Parameters:
NumStages, 4, number of cascade stages sharing the engine (>=1)
DataWidth, 16, sample width in bits (two's complement, treated opaquely)
CntWidth, 16, width of status counters
StageIdxWidth, (NumStages>1 ? $clog2(NumStages) : 1), derived; not to be overridden

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
cfg_en_i  in  1  scheduler enable; 0 = new samples ignored
cfg_bypass_i  in  NumStages  bit s=1 skips stage s
cfg_clr_i  in  1  synchronous clear of both status counters
in_valid_i  in  1  single-cycle sample strobe; no backpressure
in_data_i  in  DataWidth  input sample
eng_req_o  out  1  engine request
eng_stage_o  out  StageIdxWidth  stage index for the request
eng_data_o  out  DataWidth  operand for the request
eng_gnt_i  in  1  engine grant
eng_rvalid_i  in  1  engine result valid
eng_rdata_i  in  DataWidth  engine result
out_valid_o  out  1  processed sample valid
out_data_o  out  DataWidth  processed sample
out_ready_i  in  1  downstream ready
busy_o  out  1  sample in flight (state != IDLE)
sample_cnt_o  out  CntWidth  completed output handshakes; wraps
overrun_cnt_o  out  CntWidth  dropped strobes; saturates at all-ones

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; acc, stage index and latched mask = 0.
  - All outputs 0.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - Accept condition: in_valid_i & cfg_en_i.
  - On accept: acc<=in_data_i; mask<=cfg_bypass_i.
  - Stage search: idx<=lowest s with cfg_bypass_i[s]=0, then go to ISSUE.
  - If every stage is bypassed, go to OUT instead.
  - in_valid_i while cfg_en_i=0: ignored and not counted.
- ISSUE:
  - Drive eng_req_o=1, eng_stage_o=idx, eng_data_o=acc.
  - These values stay stable until eng_gnt_i=1; no retraction.
  - The grant cycle completes the request; next state is WAIT.
- WAIT:
  - eng_req_o=0.
  - On eng_rvalid_i: acc<=eng_rdata_i.
  - idx<=next s>idx with mask[s]=0; go to ISSUE if one exists, otherwise OUT.
  - eng_rvalid_i is only sampled in WAIT. rvalid in the grant cycle is not consumed; the engine must return data at least 1 cycle after gnt.
- OUT:
  - out_valid_o=1, out_data_o=acc, held stable until out_ready_i.
  - On the handshake: sample_cnt_o++ (wrap), next state IDLE.
  - A new sample is accepted at earliest the cycle after the handshake.
- Outside IDLE:
  - eng_stage_o and eng_data_o are 0 when eng_req_o=0.
  - out_data_o is 0 when out_valid_o=0.
- Overrun: in_valid_i & cfg_en_i in any state other than IDLE drops the sample; overrun_cnt_o++ saturating. This includes the OUT handshake cycle.
- Latched mask: the mask is captured per sample, so cfg_bypass_i changes mid-sample take effect on the next sample.
- cfg_en_i falling mid-sample: the current sample completes normally.
- cfg_clr_i: both counters go to 0 next cycle. If clear and an increment happen in the same cycle, clear wins. The FSM is unaffected.
- Latency, with gnt in the first ISSUE cycle and rvalid in the cycle after gnt:
  - Accept at edge 0; each enabled stage takes 2 cycles.
  - out_valid_o rises 1+2K cycles after accept, K = number of enabled stages.
  - K=0: out_valid_o rises 1 cycle after accept.
- Stall: no timeout; the FSM waits indefinitely on gnt, rvalid or out_ready.

Test Plan:
- Reset mid-WAIT -> next cycle busy_o=0, eng_req_o=0, out_valid_o=0; a new strobe is accepted immediately.
- cfg_bypass_i=4'b0000, engine returns input+1, in_data_i=16'h0010 -> eng_stage_o sequence 0,1,2,3; out_data_o=16'h0014; out_valid_o 9 cycles after accept; sample_cnt_o=1.
- cfg_bypass_i=4'b1010, same engine, in_data_i=16'h0100 -> only stages 0 and 2 requested; out_data_o=16'h0102. With cfg_bypass_i=4'b1111 -> no eng_req_o; out_data_o=16'h0100 one cycle after accept.
- Engine delays gnt by 3 cycles and out_ready_i is held low 5 cycles -> eng_req_o, eng_stage_o, eng_data_o and out_data_o stay stable throughout; exactly one handshake of each.
- Three strobes while busy, one of them on the OUT handshake cycle -> overrun_cnt_o=3; strobes with cfg_en_i=0 leave it unchanged.
- overrun_cnt_o preloaded to 16'hFFFF by 65535 overruns plus one more -> stays 16'hFFFF. cfg_clr_i asserted in the same cycle as an increment -> both counters 0.
